// File: rtl/bb_sgpio_pkg.sv
// Shared definitions for the baseboard SGPIO initiator: FSM encoding,
// slot bit order within a drive triplet and frame-length derivation.
package bb_sgpio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } sgpio_state_e;

  localparam int SLOT_ACT  = 0;
  localparam int SLOT_LOC  = 1;
  localparam int SLOT_FAIL = 2;

  function automatic int frame_bits(input int drv_num);
    return 3 * drv_num;
  endfunction

endpackage

// File: rtl/bb_sgpio_clkgen.sv
// SGPIO clock generator: divides clk by 2*CLK_DIV and flags the rise/fall
// cycles. Once run drops, the clock finishes its current high phase and parks low.
module bb_sgpio_clkgen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic ck,
  output logic ck_r,
  output logic ck_f
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ck_q, ck_d;
  logic          active, wrap;

  always_comb begin
    active = run | ck_q;
    wrap   = active && (cnt_q == CW'(CLK_DIV - 1));
    cnt_d  = '0;
    ck_d   = ck_q;
    if (active) cnt_d = wrap ? '0 : cnt_q + 1'b1;
    if (wrap) ck_d = ~ck_q;
    ck_r = wrap & ~ck_q;
    ck_f = wrap & ck_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ck_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ck_q  <= ck_d;
    end
  end

  assign ck = ck_q;

endmodule

// File: rtl/bb_sgpio_tx.sv
// SGPIO initiator: serialises {FAIL,LOC,ACT} per drive onto SGPIO_DATA with a
// slot-0 LD marker, and captures SGPIO_DIN into DIN_STATUS once per frame.
module bb_sgpio_tx
  import bb_sgpio_pkg::*;
#(
  parameter int DRV_NUM        = 36,
  parameter int CLK_DIV        = 250,
  parameter int ACT_ACTIVE_LOW = 1,
  parameter int IDLE_GAP       = 4
) (
  input  logic                   SYSCLK,
  input  logic                   RESET_N,
  input  logic                   EN,
  input  logic [DRV_NUM-1:0]     DRV_ACT,
  input  logic [DRV_NUM-1:0]     DRV_LOC,
  input  logic [DRV_NUM-1:0]     DRV_FAIL,
  input  logic                   SGPIO_DIN,
  output logic                   SGPIO_CK,
  output logic                   SGPIO_LD,
  output logic                   SGPIO_DATA,
  output logic [3*DRV_NUM-1:0]   DIN_STATUS,
  output logic                   FRAME_DONE
);

  localparam int   N       = frame_bits(DRV_NUM);
  localparam int   SW      = $clog2(N);
  localparam int   GW      = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic ACT_INV = (ACT_ACTIVE_LOW != 0);

  sgpio_state_e  state_q, state_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [N-1:0]  cap_q, cap_d;
  logic [N-1:0]  din_q, din_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          data_q, data_d;
  logic          ld_q, ld_d;
  logic          done_q, done_d;
  logic [N-1:0]  snap;
  logic          ck_r, ck_f;

  bb_sgpio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk   (SYSCLK),
    .rst_n (RESET_N),
    .run   (state_q != ST_IDLE),
    .ck    (SGPIO_CK),
    .ck_r  (ck_r),
    .ck_f  (ck_f)
  );

  always_comb begin
    snap = '0;
    for (int i = 0; i < DRV_NUM; i++) begin
      snap[3*i+SLOT_ACT]  = DRV_ACT[i] ^ ACT_INV;
      snap[3*i+SLOT_LOC]  = DRV_LOC[i];
      snap[3*i+SLOT_FAIL] = DRV_FAIL[i];
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cap_d   = cap_q;
    din_d   = din_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    data_d  = data_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (EN) state_d = ST_LOAD;
      // Slot 0 goes out straight from the snapshot while CK is still low.
      ST_LOAD: begin
        sh_d    = snap >> 1;
        data_d  = snap[0];
        ld_d    = 1'b1;
        slot_d  = '0;
        cap_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ck_r) begin
          cap_d = {SGPIO_DIN, cap_q[N-1:1]};
          if (slot_q == SW'(N - 1)) begin
            din_d   = cap_d;
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
        if (ck_f) begin
          slot_d = slot_q + 1'b1;
          data_d = sh_q[0];
          sh_d   = sh_q >> 1;
          ld_d   = 1'b0;
        end
      end
      // The first fall here closes slot N-1; IDLE_GAP more falls end the gap.
      ST_GAP: begin
        if (ck_f) begin
          data_d = 1'b0;
          ld_d   = 1'b0;
          if (gap_q == GW'(IDLE_GAP)) state_d = EN ? ST_LOAD : ST_IDLE;
          else gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cap_q   <= '0;
      din_q   <= '0;
      slot_q  <= '0;
      gap_q   <= '0;
      data_q  <= 1'b0;
      ld_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cap_q   <= cap_d;
      din_q   <= din_d;
      slot_q  <= slot_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
    end
  end

  assign SGPIO_LD   = ld_q;
  assign SGPIO_DATA = data_q;
  assign DIN_STATUS = din_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_bb_sgpio_tx.sv
// Bench for bb_sgpio_tx (4 drives, CK half-period 4, 2-period gap): observes the
// serial line at each SGPIO_CK rise and compares against a slot-rule model.
module tb_bb_sgpio_tx;

  localparam int DRV  = 4;
  localparam int CDIV = 4;
  localparam int GAPN = 2;
  localparam int N    = 3 * DRV;

  logic           sysclk = 1'b0;
  logic           reset_n = 1'b0;
  logic           en = 1'b0;
  logic [DRV-1:0] drv_act = '1;
  logic [DRV-1:0] drv_loc = '0;
  logic [DRV-1:0] drv_fail = '0;
  logic           din = 1'b0;
  logic           ck, ld, data, done;
  logic [N-1:0]   status;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  done_total = 0;
  int  last_start = -1;
  logic prev_ck = 1'b0;

  typedef struct {
    logic [DRV-1:0] act;
    logic [DRV-1:0] loc;
    logic [DRV-1:0] fail;
    logic [N-1:0]   din;
    logic [N-1:0]   exp_data;
  } vec_t;

  vec_t vecs[4];

  // ---------------- clock / reset ----------------
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc++;
  always @(negedge sysclk) if (done) done_total++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  bb_sgpio_tx #(
    .DRV_NUM(DRV), .CLK_DIV(CDIV), .ACT_ACTIVE_LOW(1), .IDLE_GAP(GAPN)
  ) dut (
    .SYSCLK     (sysclk),
    .RESET_N    (reset_n),
    .EN         (en),
    .DRV_ACT    (drv_act),
    .DRV_LOC    (drv_loc),
    .DRV_FAIL   (drv_fail),
    .SGPIO_DIN  (din),
    .SGPIO_CK   (ck),
    .SGPIO_LD   (ld),
    .SGPIO_DATA (data),
    .DIN_STATUS (status),
    .FRAME_DONE (done)
  );

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] model_frame(input logic [DRV-1:0] a,
                                               input logic [DRV-1:0] l,
                                               input logic [DRV-1:0] f);
    logic [N-1:0] r;
    r = '0;
    for (int s = 0; s < N; s++) begin
      int d;
      d = s / 3;
      case (s % 3)
        0:       r[s] = ~a[d];
        1:       r[s] = l[d];
        default: r[s] = f[d];
      endcase
    end
    return r;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(output bit rise);
    @(negedge sysclk);
    rise = ck && !prev_ck;
    prev_ck = ck;
  endtask

  // hook_kind: 0 none, 1 change LOC to hook_val, 2 drop EN, 3 assert reset
  task automatic do_frame(input string name,
                          input logic [DRV-1:0] a, input logic [DRV-1:0] l,
                          input logic [DRV-1:0] f, input logic [N-1:0] dp,
                          input logic [N-1:0] exp_d,
                          input int hook_slot, input int hook_kind,
                          input logic [DRV-1:0] hook_val,
                          input bit chk_gap, input bit strict);
    logic [N-1:0] got_d, got_ld;
    int  k, budget, d0;
    int  rise_cyc[N];
    bit  r, started, aborted, first;
    drv_act = a; drv_loc = l; drv_fail = f; din = dp[0];
    got_d = '0; got_ld = '0; k = 0; budget = 0;
    started = 0; aborted = 0; first = 1;
    d0 = done_total;
    foreach (rise_cyc[i]) rise_cyc[i] = 0;
    while (k < N && budget < 800 && !aborted) begin
      step(r);
      budget++;
      if (r) begin
        if (strict && first) check({name, " first rise LD"}, 32'(ld), 32'd1);
        first = 0;
        if (!started && ld) started = 1;
        if (started) begin
          got_d[k] = data; got_ld[k] = ld; rise_cyc[k] = cyc;
          k++;
          if (k < N) din = dp[k];
          if (k == hook_slot + 1) begin
            case (hook_kind)
              1: drv_loc = hook_val;
              2: en = 1'b0;
              3: begin reset_n = 1'b0; aborted = 1; end
              default: ;
            endcase
          end
        end
      end
    end
    if (aborted) begin
      repeat (3) step(r);
      check({name, " reset outputs"}, {28'd0, ck, ld, data, done}, 32'd0);
      check({name, " reset status"}, 32'(status), 32'd0);
      return;
    end
    check({name, " slots seen"}, k, N);
    repeat (4) step(r);
    check({name, " data"}, 32'(got_d), 32'(exp_d));
    check({name, " ld"}, 32'(got_ld), 32'h1);
    check({name, " status"}, 32'(status), 32'(dp));
    check({name, " done pulses"}, done_total - d0, 1);
    check({name, " ck period"}, rise_cyc[N-1] - rise_cyc[0], (N - 1) * 2 * CDIV);
    if (chk_gap) check({name, " frame interval"}, rise_cyc[0] - last_start, (N + GAPN) * 2 * CDIV);
    last_start = rise_cyc[0];
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit r;
    int nz, rises, ldh, ckh;
    logic [DRV-1:0] a, l, f, l2;
    logic [N-1:0]   dp;

    vecs[0] = '{act: 4'b1110, loc: 4'b0100, fail: 4'b1000, din: 12'hA5C, exp_data: 12'h881};
    vecs[1] = '{act: 4'b1111, loc: 4'b0000, fail: 4'b0000, din: 12'h000, exp_data: 12'h000};
    vecs[2] = '{act: 4'b0000, loc: 4'b1111, fail: 4'b1111, din: 12'hFFF, exp_data: 12'hFFF};
    vecs[3] = '{act: 4'b0111, loc: 4'b0001, fail: 4'b0010, din: 12'h5A3, exp_data: 12'h222};

    repeat (3) step(r);
    check("in reset outputs", {28'd0, ck, ld, data, done}, 32'd0);
    check("in reset status", 32'(status), 32'd0);
    reset_n = 1'b1;
    nz = 0;
    for (int i = 0; i < 200; i++) begin
      step(r);
      if (ck || ld || data || done || (status != '0)) nz++;
    end
    check("idle en=0 nonzero samples", nz, 0);

    en = 1'b1;
    for (int i = 0; i < 4; i++)
      do_frame($sformatf("vec%0d", i), vecs[i].act, vecs[i].loc, vecs[i].fail,
               vecs[i].din, vecs[i].exp_data, -1, 0, '0, i > 0, 0);

    a = 4'b1010; l = 4'b0011; f = 4'b0100; l2 = ~l;
    do_frame("loc toggle cur", a, l, f, 12'h3C6, model_frame(a, l, f), 4, 1, l2, 1, 0);
    do_frame("loc toggle next", a, l2, f, 12'h9E1, model_frame(a, l2, f), -1, 0, '0, 1, 0);

    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 15)); l = 4'($urandom_range(0, 15));
      f = 4'($urandom_range(0, 15)); dp = 12'($urandom_range(0, 4095));
      do_frame($sformatf("rand%0d", i), a, l, f, dp, model_frame(a, l, f), -1, 0, '0, 1, 0);
    end

    a = 4'($urandom_range(0, 15)); l = 4'($urandom_range(0, 15));
    f = 4'($urandom_range(0, 15)); dp = 12'($urandom_range(1, 4095));
    do_frame("en drop", a, l, f, dp, model_frame(a, l, f), 5, 2, '0, 1, 0);
    rises = 0; ldh = 0; ckh = 0;
    for (int i = 0; i < 300; i++) begin
      step(r);
      if (r) rises++;
      if (ld) ldh++;
      if (i >= 200 && ck) ckh++;
    end
    check("stop gap ck rises", rises, GAPN);
    check("stop ld samples", ldh, 0);
    check("stop ck parked low", ckh, 0);

    en = 1'b1;
    a = 4'b0101; l = 4'b1100; f = 4'b0011;
    do_frame("reset slot7", a, l, f, 12'h7E5, model_frame(a, l, f), 7, 3, '0, 0, 0);
    reset_n = 1'b1;
    a = 4'($urandom_range(0, 15)); l = 4'($urandom_range(0, 15));
    f = 4'($urandom_range(0, 15)); dp = 12'($urandom_range(0, 4095));
    do_frame("after reset", a, l, f, dp, model_frame(a, l, f), -1, 0, '0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
